// File: rtl/fpu_trig_range_precheck_if.sv
// Handshake bundle for the trig range precheck: request/response towards the
// FPU core and the level request/pulse reply towards the range reducer.
interface fpu_trig_range_precheck_if;
  logic        start;
  logic [79:0] operand_in;
  logic        busy;
  logic        done;
  logic [79:0] result_out;
  logic [1:0]  quadrant_out;
  logic        c2_out;
  logic        invalid_out;
  logic        red_enable;
  logic [79:0] red_angle;
  logic        red_done;
  logic [79:0] red_angle_out;
  logic [1:0]  red_quadrant;
  logic        red_error;

  modport slave (
    input  start, operand_in, red_done, red_angle_out, red_quadrant, red_error,
    output busy, done, result_out, quadrant_out, c2_out, invalid_out,
           red_enable, red_angle
  );

  modport master (
    output start, operand_in, red_done, red_angle_out, red_quadrant, red_error,
    input  busy, done, result_out, quadrant_out, c2_out, invalid_out,
           red_enable, red_angle
  );
endinterface

// File: rtl/fpu_trig_range_precheck.sv
// Classifies an 80-bit extended operand before a trig op: specials and
// out-of-range values finish locally, the rest go to the external reducer.
module fpu_trig_range_precheck #(
  parameter logic [14:0] TINY_EXP       = 15'h3FDF,
  parameter logic [14:0] OOR_EXP        = 15'h403E,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input logic                        clk,
  input logic                        reset,
  fpu_trig_range_precheck_if.slave   bus
);

  localparam logic [79:0] DEFAULT_NAN = 80'hFFFF_C000_0000_0000_0000;
  localparam int unsigned CW          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CLASSIFY, REDUCE, FINISH} state_t;

  state_t        state, state_next;
  logic [79:0]   op;
  logic [CW-1:0] cnt;

  logic          load;
  logic [79:0]   f_res;
  logic [1:0]    f_quad;
  logic          f_c2;
  logic          f_inv;

  logic [14:0]   op_exp;
  assign op_exp = op[78:64];

  always_comb begin
    state_next = state;
    load       = 1'b0;
    f_res      = '0;
    f_quad     = '0;
    f_c2       = 1'b0;
    f_inv      = 1'b0;
    unique case (state)
      IDLE: if (bus.start) state_next = CLASSIFY;
      CLASSIFY: begin
        state_next = FINISH;
        load       = 1'b1;
        if (op_exp == 15'h7FFF && op[62:0] == '0) begin
          f_inv = 1'b1;
          f_res = DEFAULT_NAN;
        end else if (op_exp == 15'h7FFF) begin
          f_res     = op;
          f_res[62] = 1'b1;
          f_inv     = ~op[62];
        end else if (op_exp != '0 && !op[63]) begin
          f_inv = 1'b1;
          f_res = DEFAULT_NAN;
        end else if (op_exp == '0 || op_exp < TINY_EXP) begin
          f_res = op;
        end else if (op_exp >= OOR_EXP) begin
          f_c2  = 1'b1;
          f_res = op;
        end else begin
          state_next = REDUCE;
          load       = 1'b0;
        end
      end
      REDUCE: begin
        // a reply on the final wait cycle wins over the timeout
        if (bus.red_done) begin
          state_next = FINISH;
          load       = 1'b1;
          if (bus.red_error) begin
            f_inv = 1'b1;
            f_res = DEFAULT_NAN;
          end else if (op[79]) begin
            f_res  = {~bus.red_angle_out[79], bus.red_angle_out[78:0]};
            f_quad = 2'd0 - bus.red_quadrant;
          end else begin
            f_res  = bus.red_angle_out;
            f_quad = bus.red_quadrant;
          end
        end else if (cnt == CNT_LAST) begin
          state_next = FINISH;
          load       = 1'b1;
          f_inv      = 1'b1;
          f_res      = DEFAULT_NAN;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      op               <= '0;
      cnt              <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.result_out   <= '0;
      bus.quadrant_out <= '0;
      bus.c2_out       <= 1'b0;
      bus.invalid_out  <= 1'b0;
      bus.red_enable   <= 1'b0;
      bus.red_angle    <= '0;
    end else begin
      state          <= state_next;
      bus.busy       <= (state_next != IDLE);
      bus.done       <= (state_next == FINISH);
      bus.red_enable <= (state_next == REDUCE);
      if (state == IDLE && bus.start) op <= bus.operand_in;
      if (state == CLASSIFY && state_next == REDUCE) begin
        bus.red_angle <= {1'b0, op[78:0]};
        cnt           <= '0;
      end else if (state == REDUCE) begin
        cnt <= cnt + 1'b1;
      end
      if (load) begin
        bus.result_out   <= f_res;
        bus.quadrant_out <= f_quad;
        bus.c2_out       <= f_c2;
        bus.invalid_out  <= f_inv;
      end
    end
  end

endmodule

// File: tb/tb_fpu_trig_range_precheck.sv
// Scoreboard bench for fpu_trig_range_precheck with a behavioural reducer model.
`timescale 1ns/1ps
module tb_fpu_trig_range_precheck;

  localparam logic [14:0] TINY_EXP = 15'h3FDF;
  localparam logic [14:0] OOR_EXP  = 15'h403E;
  localparam int          TIMEOUT  = 1023;
  localparam logic [79:0] NAN      = 80'hFFFF_C000_0000_0000_0000;
  localparam logic [79:0] TWO_PI   = 80'h4001_C90F_DAA2_2168_C235;
  localparam logic [79:0] NEG_PI   = 80'hC000_C90F_DAA2_2168_C235;

  typedef struct {
    logic [79:0] res;
    logic [1:0]  quad;
    logic        c2;
    logic        inv;
    int          cyc;
  } exp_t;

  typedef struct {
    int          delay;
    logic [79:0] ang_in;
    logic [79:0] ang_out;
    logic [1:0]  q;
    logic        err;
    int          exp_high;
  } plan_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fpu_trig_range_precheck_if bus();

  fpu_trig_range_precheck #(
    .TINY_EXP(TINY_EXP),
    .OOR_EXP(OOR_EXP),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int   cyc = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    stray_req = 0;
  bit    end_req = 1'b0;
  bit    end_ack = 1'b0;

  // Reference: classification and reducer-reply folding from the rules.
  function automatic void model(input logic [79:0] op, input int delay,
                                input logic [79:0] ang, input logic [1:0] q,
                                input logic err, output exp_t e, output bit red);
    int ex;
    ex = int'(op[78:64]);
    e.res = op; e.quad = 2'd0; e.c2 = 1'b0; e.inv = 1'b0; e.cyc = 0;
    red = 1'b0;
    if (ex == 32767 && op[62:0] == 63'd0) begin
      e.inv = 1'b1; e.res = NAN;
    end else if (ex == 32767) begin
      e.res[62] = 1'b1; e.inv = !op[62];
    end else if (ex != 0 && !op[63]) begin
      e.inv = 1'b1; e.res = NAN;
    end else if (ex < int'(TINY_EXP)) begin
      e.res = op;
    end else if (ex >= int'(OOR_EXP)) begin
      e.c2 = 1'b1;
    end else begin
      red = 1'b1;
      if (delay < 0 || delay >= TIMEOUT || err) begin
        e.inv = 1'b1; e.res = NAN;
      end else begin
        e.res  = op[79] ? {!ang[79], ang[78:0]} : ang;
        e.quad = op[79] ? 2'((4 - int'(q)) % 4) : q;
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Monitor and reducer model share one process.
  exp_t  e_m;
  plan_t cur;
  bit    active = 1'b0;
  bit    prev_done = 1'b0;
  int    hi = 0;
  int    stray_seen = 0;

  always @(negedge clk) begin
    bus.red_done  = 1'b0;
    bus.red_error = 1'b0;
    if (rst_q) begin
      chk("rst_busy", 80'(bus.busy), 80'd0);
      chk("rst_done", 80'(bus.done), 80'd0);
      chk("rst_result", bus.result_out, 80'd0);
      chk("rst_quadrant", 80'(bus.quadrant_out), 80'd0);
      chk("rst_c2", 80'(bus.c2_out), 80'd0);
      chk("rst_invalid", 80'(bus.invalid_out), 80'd0);
      chk("rst_red_enable", 80'(bus.red_enable), 80'd0);
      chk("rst_red_angle", bus.red_angle, 80'd0);
      prev_done = 1'b0;
      active    = 1'b0;
    end else begin
      if (bus.done) begin
        chk("done_width", 80'(prev_done), 80'd0);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: done=1 with no request pending, required done=0");
        end else begin
          e_m = exp_q.pop_front();
          chk("result", bus.result_out, e_m.res);
          chk("quadrant", 80'(bus.quadrant_out), 80'(e_m.quad));
          chk("c2", 80'(bus.c2_out), 80'(e_m.c2));
          chk("invalid", 80'(bus.invalid_out), 80'(e_m.inv));
          chk("done_cycle", 80'(cyc), 80'(e_m.cyc));
          chk("c2_inv_excl", 80'(bus.c2_out & bus.invalid_out), 80'd0);
        end
      end
      prev_done = bus.done;

      if (!active && bus.red_enable) begin
        if (plan_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_red_enable: red_enable=1, required 0");
          cur.delay = -1; cur.exp_high = -1; cur.ang_in = bus.red_angle;
          cur.ang_out = '0; cur.q = 2'd0; cur.err = 1'b0;
        end else begin
          cur = plan_q.pop_front();
        end
        active = 1'b1;
        hi     = 0;
      end
      if (active) begin
        if (bus.red_enable) begin
          chk("red_angle", bus.red_angle, cur.ang_in);
          if (hi == cur.delay) begin
            bus.red_done      = 1'b1;
            bus.red_error     = cur.err;
            bus.red_angle_out = cur.ang_out;
            bus.red_quadrant  = cur.q;
          end
          hi++;
        end else begin
          active = 1'b0;
          if (cur.exp_high >= 0) chk("red_enable_cycles", 80'(hi), 80'(cur.exp_high));
        end
      end else if (stray_req != stray_seen) begin
        stray_seen++;
        bus.red_done      = 1'b1;
        bus.red_error     = 1'($urandom_range(0, 1));
        bus.red_angle_out = {16'($urandom), $urandom, $urandom};
        bus.red_quadrant  = 2'($urandom);
      end
    end
    if (end_req && !end_ack) begin
      chk("pending_at_end", 80'(exp_q.size()), 80'd0);
      end_ack = 1'b1;
    end
  end

  task automatic wait_idle(input int pulse_at);
    bit pulsing;
    pulsing = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (pulsing) begin
        bus.start = 1'b0;
        pulsing   = 1'b0;
      end
      if (!bus.busy) return;
      if (i == pulse_at) begin
        bus.start      = 1'b1;
        bus.operand_in = {16'($urandom), $urandom, $urandom};
        pulsing        = 1'b1;
      end
    end
    $display("FAIL wait_idle: busy still 1 after 3000 cycles, required 0");
    $fatal(1);
  endtask

  task automatic issue(input logic [79:0] op, input int delay, input logic [79:0] ang,
                       input logic [1:0] q, input logic err, input bit track,
                       input int pulse_at);
    exp_t  e;
    plan_t p;
    bit    red;
    model(op, delay, ang, q, err, e, red);
    if (red) begin
      p.delay    = delay;
      p.ang_in   = {1'b0, op[78:0]};
      p.ang_out  = ang;
      p.q        = q;
      p.err      = err;
      p.exp_high = !track ? -1 : ((delay < 0 || delay >= TIMEOUT) ? TIMEOUT : delay + 1);
      plan_q.push_back(p);
    end
    e.cyc = cyc + (!red ? 2 : ((delay < 0 || delay >= TIMEOUT) ? TIMEOUT + 2 : delay + 3));
    if (track) exp_q.push_back(e);
    bus.start      = 1'b1;
    bus.operand_in = op;
    @(negedge clk);
    bus.start = 1'b0;
    if (track) wait_idle(pulse_at);
  endtask

  function automatic logic [79:0] rand_op();
    logic [14:0] ex;
    logic [63:0] m;
    m = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: begin ex = 15'h7FFF; m[62:0] = '0; end
      1: begin ex = 15'h7FFF; if (m[62:0] == 63'd0) m[0] = 1'b1; end
      2: begin ex = 15'($urandom_range(1, 32766)); m[63] = 1'b0; end
      3: ex = 15'd0;
      4: begin ex = 15'($urandom_range(1, int'(TINY_EXP) - 1)); m[63] = 1'b1; end
      5: begin ex = 15'($urandom_range(int'(OOR_EXP), 32766)); m[63] = 1'b1; end
      default: begin ex = 15'($urandom_range(int'(TINY_EXP), int'(OOR_EXP) - 1)); m[63] = 1'b1; end
    endcase
    return {1'($urandom), ex, m};
  endfunction

  initial begin
    bus.start      = 1'b0;
    bus.operand_in = '0;
    reset          = 1'b1;
    repeat (4) @(negedge clk);

    // start on the very first edge with reset low
    reset = 1'b0;
    issue(TWO_PI, 4, 80'd0, 2'd0, 1'b0, 1'b1, -1);
    issue(NEG_PI, 7, 80'h3FFE_8000_0000_0000_0000, 2'd1, 1'b0, 1'b1, 2);
    issue(80'h8000_0000_0000_0000_0000, 0, 80'd0, 2'd0, 1'b0, 1'b1, -1);
    issue(80'h7FFF_8000_0000_0000_0000, 0, 80'd0, 2'd0, 1'b0, 1'b1, 0);
    issue(80'h403E_8000_0000_0000_0000, 0, 80'd0, 2'd0, 1'b0, 1'b1, 1);
    issue(TWO_PI, -1, 80'd0, 2'd0, 1'b0, 1'b1, 500);
    issue(NEG_PI, 2, {16'($urandom), $urandom, $urandom}, 2'd2, 1'b0, 1'b1, -1);
    issue(TWO_PI, TIMEOUT - 1, {16'($urandom), $urandom, $urandom}, 2'd3, 1'b0, 1'b1, -1);
    issue(NEG_PI, 3, {16'($urandom), $urandom, $urandom}, 2'd1, 1'b1, 1'b1, -1);

    stray_req++;
    repeat (4) @(negedge clk);

    issue(TWO_PI, -1, 80'd0, 2'd0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 20 && !bus.red_enable; i++) @(negedge clk);
    if (!bus.red_enable) begin
      $display("FAIL wait_red_enable: red_enable=0, required 1");
      $fatal(1);
    end
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    for (int n = 0; n < 60; n++) begin
      issue(rand_op(), $urandom_range(0, 12), {16'($urandom), $urandom, $urandom},
            2'($urandom), 1'($urandom_range(0, 9) == 0), 1'b1,
            ($urandom_range(0, 1) == 1) ? $urandom_range(0, 6) : -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_ack; i++) @(negedge clk);
    if (!end_ack) begin
      $display("FAIL end_handshake: end_ack=0, required 1");
      $fatal(1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
